// File: rtl/adc_dual_slope_ctrl.sv
// adc_dual_slope_ctrl -- dual-slope ADC sequencer with N-digit BCD counter.
//
// One Moore FSM (IDLE, AZ, INT, DEINT, LOAD) drives the three analog
// switches, runs a separate auto-zero timer and steers a ripple-carry BCD
// counter.  The counter measures the fixed 10^DIGITS integrate phase and
// then the de-integrate time up to the first zero crossing.  The result is
// latched into bcd/ovr as LOAD is entered.
//
// Parameters:
//   DIGITS    - number of BCD digits, full scale 10^DIGITS counts (1..6)
//   AZ_CYCLES - auto-zero phase length in clock cycles (>= 1)
// Ports:
//   ck      in   clock, rising edge
//   rst     in   asynchronous reset, active high
//   inicio  in   start request (level), looked at only in IDLE
//   cont    in   continuous mode, looked at only in LOAD
//   Vint_z  in   integrator zero-crossing comparator, looked at only in DEINT
//   ch_zr   out  zero switch (IDLE, AZ, LOAD)
//   ch_vm   out  input-voltage switch (INT)
//   ch_ref  out  reference switch (DEINT)
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse while the new result is presented
//   ovr     out  overrange flag of the last conversion
//   bcd     out  latched result, digit 0 (units) in bits [3:0]
//   sgm     out  seven-segment decode of bcd, 7 bits per digit (a=bit0 ..
//                g=bit6, active high); exists only when ADC_SEG7_EN is defined
//
// Optional feature macro: ADC_SEG7_EN (adds the sgm port and its decoder).

// One BCD digit of the counter.  The carry into the next digit is formed in
// the parent from cin and nine, so the chain stays visible in one place.
module adc_bcd_digit (
  input  logic       ck,
  input  logic       rst,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] q,
  output logic       nine
);
  assign nine = (q == 4'd9);

  always_ff @(posedge ck or posedge rst)
    if (rst)      q <= 4'd0;
    else if (clr) q <= 4'd0;
    else if (cin) q <= nine ? 4'd0 : q + 4'd1;
endmodule

module adc_dual_slope_ctrl #(
  parameter int DIGITS    = 3,
  parameter int AZ_CYCLES = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                inicio,
  input  logic                cont,
  input  logic                Vint_z,
  output logic                ch_zr,
  output logic                ch_vm,
  output logic                ch_ref,
  output logic                busy,
  output logic                done,
  output logic                ovr,
  output logic [4*DIGITS-1:0] bcd
`ifdef ADC_SEG7_EN
  ,
  output logic [7*DIGITS-1:0] sgm
`endif
);

  localparam int AZW = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AZ, S_INT, S_DEINT, S_LOAD} state_t;

  state_t                  state, state_nx;
  logic [AZW-1:0]          az_tmr;
  logic [DIGITS-1:0][3:0]  cnt;
  logic [DIGITS-1:0]       nine;
  logic [DIGITS-1:0]       carry;
  logic                    all9;
  logic                    az_last;
  logic                    cnt_clr;
  logic                    cnt_inc;

  assign all9    = &nine;
  assign az_last = (az_tmr == AZW'(AZ_CYCLES - 1));

  // ---------------- BCD counter: ripple carry across digits ----------------
  // Counter is cleared outside INT/DEINT.  INT counts freely (the all-9s
  // wrap brings it back to 0 for DEINT).  DEINT freezes on the zero
  // crossing or at full scale; LOAD then clears it.
  assign cnt_clr = (state == S_IDLE) || (state == S_AZ) || (state == S_LOAD);
  assign cnt_inc = (state == S_INT) ||
                   ((state == S_DEINT) && !Vint_z && !all9);

  assign carry[0] = cnt_inc;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    adc_bcd_digit u_dig (
      .ck   (ck),
      .rst  (rst),
      .clr  (cnt_clr),
      .cin  (carry[i]),
      .q    (cnt[i]),
      .nine (nine[i])
    );
    if (i < DIGITS - 1) begin : g_cy
      assign carry[i+1] = carry[i] & nine[i];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge ck or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (inicio)          state_nx = S_AZ;
      S_AZ:    if (az_last)         state_nx = S_INT;
      S_INT:   if (all9)            state_nx = S_DEINT;
      S_DEINT: if (Vint_z || all9)  state_nx = S_LOAD;
      S_LOAD:  state_nx = cont ? S_AZ : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Auto-zero timer: counts only while AZ continues, so it is 0 on every
  // entry into AZ (from IDLE or straight from LOAD in continuous mode).
  always_ff @(posedge ck or posedge rst)
    if (rst)                                     az_tmr <= '0;
    else if (state == S_AZ && state_nx == S_AZ)  az_tmr <= az_tmr + 1'b1;
    else                                         az_tmr <= '0;

  // Outputs are registered from the next state so they change exactly with
  // the state register and never glitch.
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      ch_zr  <= 1'b1;
      ch_vm  <= 1'b0;
      ch_ref <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ch_zr  <= (state_nx == S_IDLE) || (state_nx == S_AZ) ||
                (state_nx == S_LOAD);
      ch_vm  <= (state_nx == S_INT);
      ch_ref <= (state_nx == S_DEINT);
      busy   <= (state_nx != S_IDLE);
      done   <= (state_nx == S_LOAD);
    end

  // Result latch.  A zero crossing on the all-9s cycle still counts as an
  // in-range result, so Vint_z is tested first.
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      bcd <= '0;
      ovr <= 1'b0;
    end else if (state == S_DEINT) begin
      if (Vint_z) begin
        bcd <= cnt;
        ovr <= 1'b0;
      end else if (all9) begin
        bcd <= {DIGITS{4'h9}};
        ovr <= 1'b1;
      end
    end

`ifdef ADC_SEG7_EN
  // ---------------- seven-segment decode of the latched result ----------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    logic [6:0] seg;
    always_comb begin
      seg = 7'h00;                    // non-BCD codes stay blank
      case (bcd[4*i +: 4])
        4'd0: seg = 7'h3F;
        4'd1: seg = 7'h06;
        4'd2: seg = 7'h5B;
        4'd3: seg = 7'h4F;
        4'd4: seg = 7'h66;
        4'd5: seg = 7'h6D;
        4'd6: seg = 7'h7D;
        4'd7: seg = 7'h07;
        4'd8: seg = 7'h7F;
        4'd9: seg = 7'h6F;
        default: seg = 7'h00;
      endcase
    end
    // Overrange shows a dash (segment g) on every digit.
    assign sgm[7*i +: 7] = ovr ? 7'h40 : seg;
  end
`endif

endmodule

// File: tb/tb_adc_dual_slope_ctrl.sv
// Bench for adc_dual_slope_ctrl: two instances (DIGITS=3/AZ=16 and
// DIGITS=1/AZ=1).  Stimulus pushes the expected result and done cycle into a
// per-instance queue; a monitor pops on every done pulse.  Switch/busy timing
// is checked each cycle against the phase lengths derived from the rules.
module tb_adc_dual_slope_ctrl;
  localparam int D0 = 3, AZ0 = 16;
  localparam int D1 = 1, AZ1 = 1;
  localparam logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic inicio [2];
  logic cont   [2];
  logic vz     [2];
  logic zr [2], vm [2], rf [2], busy [2], done [2], ovr [2];
  logic [4*D0-1:0] bcd0;
  logic [4*D1-1:0] bcd1;
`ifdef ADC_SEG7_EN
  logic [7*D0-1:0] sgm0;
  logic [7*D1-1:0] sgm1;
`endif

  typedef struct {
    int bcdv;
    bit ov;
    int at;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e0, e1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   tl [2];

  adc_dual_slope_ctrl #(.DIGITS(D0), .AZ_CYCLES(AZ0)) dut0 (
    .ck(ck), .rst(rst), .inicio(inicio[0]), .cont(cont[0]), .Vint_z(vz[0]),
    .ch_zr(zr[0]), .ch_vm(vm[0]), .ch_ref(rf[0]), .busy(busy[0]),
    .done(done[0]), .ovr(ovr[0]), .bcd(bcd0)
`ifdef ADC_SEG7_EN
    , .sgm(sgm0)
`endif
  );

  adc_dual_slope_ctrl #(.DIGITS(D1), .AZ_CYCLES(AZ1)) dut1 (
    .ck(ck), .rst(rst), .inicio(inicio[1]), .cont(cont[1]), .Vint_z(vz[1]),
    .ch_zr(zr[1]), .ch_vm(vm[1]), .ch_ref(rf[1]), .busy(busy[1]),
    .done(done[1]), .ovr(ovr[1]), .bcd(bcd1)
`ifdef ADC_SEG7_EN
    , .sgm(sgm1)
`endif
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal value -> packed BCD nibbles.
  function automatic int to_bcd(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 7; i++) begin
      r |= (x % 10) << (4 * i);
      x /= 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_seg(input int bcdv, input bit ov, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++)
      r[7*i +: 7] = ov ? 7'h40 : SEGS[(bcdv >> (4 * i)) & 15];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge ck) begin
    chk("onehot0", 32'(zr[0] + vm[0] + rf[0]), 1);
    chk("onehot1", 32'(zr[1] + vm[1] + rf[1]), 1);
    if (done[0] === 1'b1) begin
      if (q0.size() == 0) chk("spurious_done0", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("bcd0", 32'(bcd0), e0.bcdv);
        chk("ovr0", 32'(ovr[0]), 32'(e0.ov));
        chk("done_cycle0", cyc, e0.at);
`ifdef ADC_SEG7_EN
        chk("sgm0", 32'(sgm0), exp_seg(e0.bcdv, e0.ov, D0));
`endif
      end
    end
    if (done[1] === 1'b1) begin
      if (q1.size() == 0) chk("spurious_done1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("bcd1", 32'(bcd1), e1.bcdv);
        chk("ovr1", 32'(ovr[1]), 32'(e1.ov));
        chk("done_cycle1", cyc, e1.at);
`ifdef ADC_SEG7_EN
        chk("sgm1", 32'(sgm1), exp_seg(e1.bcdv, e1.ov, D1));
`endif
      end
    end
  end

  // One conversion on instance sel.  k = DEINT cycle of the zero crossing
  // (k >= full scale means it never comes).  fresh=1 starts from IDLE with
  // inicio; fresh=0 continues from the previous LOAD (continuous mode).
  // Called and returns on a negedge; returns on the LOAD cycle.
  task automatic convert(input int sel, input int k, input bit c, input bit fresh);
    int n  = sel ? 10 ** D1 : 10 ** D0;
    int az = sel ? AZ1 : AZ0;
    int kk = (k < n) ? k : n - 1;
    int t0, fin, r;
    exp_t e;
    if (fresh) begin
      @(negedge ck);
      inicio[sel] = 1'b1;
      t0 = cyc;
    end else t0 = tl[sel];
    fin    = t0 + az + n + kk + 2;
    e.bcdv = to_bcd(kk);
    e.ov   = (k >= n);
    e.at   = fin;
    if (sel) q1.push_back(e); else q0.push_back(e);
    while (1) begin
      r = cyc - t0;
      if (r == 1) begin
        inicio[sel] = 1'b0;
        cont[sel]   = c;
      end
      if (r == az + 5) inicio[sel] = 1'b1;      // must be ignored mid-conversion
      if (r == az + 6) inicio[sel] = 1'b0;
      if (k < n && r == az + n + 1 + k) vz[sel] = 1'b1;
      if (r >= 1) begin
        chk("ch_zr", 32'(zr[sel]), 32'(r <= az || r == fin - t0));
        chk("ch_vm", 32'(vm[sel]), 32'(r > az && r <= az + n));
        chk("ch_ref", 32'(rf[sel]), 32'(r > az + n && r < fin - t0));
        chk("busy", 32'(busy[sel]), 1);
      end
      if (r >= fin - t0) break;
      @(negedge ck);
    end
    vz[sel] = 1'b0;
    tl[sel] = fin;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_zr"},   32'(zr[0]), 1);
    chk({nm, "_vm"},   32'(vm[0]), 0);
    chk({nm, "_ref"},  32'(rf[0]), 0);
    chk({nm, "_busy"}, 32'(busy[0]), 0);
    chk({nm, "_done"}, 32'(done[0]), 0);
    chk({nm, "_ovr"},  32'(ovr[0]), 0);
    chk({nm, "_bcd"},  32'(bcd0), 0);
  endtask

  initial begin
    int  k;
    bit  c, prev_c;
    for (int i = 0; i < 2; i++) begin
      inicio[i] = 1'b0; cont[i] = 1'b0; vz[i] = 1'b0;
    end
    repeat (3) @(negedge ck);
    chk_reset_vals("reset");
    chk("reset_bcd1", 32'(bcd1), 0);
    chk("reset_busy1", 32'(busy[1]), 0);
    rst = 1'b0;
    @(negedge ck);
    chk("idle_busy", 32'(busy[0]), 0);

    // Directed cases on the 3-digit instance.
    convert(0, 250, 1'b0, 1'b1);
    convert(0, 5000, 1'b0, 1'b1);        // overrange
    convert(0, 5, 1'b1, 1'b1);           // continuous pair
    convert(0, 123, 1'b0, 1'b0);

    // Reset in the middle of INT: outputs back to reset values at once.
    @(negedge ck);
    inicio[0] = 1'b1;
    @(negedge ck);
    inicio[0] = 1'b0;
    repeat (AZ0 + 300) @(negedge ck);
    chk("mid_int_vm", 32'(vm[0]), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge ck);
    rst = 1'b0;
    convert(0, 42, 1'b0, 1'b1);

    // Boundaries.
    convert(0, 0, 1'b0, 1'b1);
    convert(0, 999, 1'b0, 1'b1);

    // Random conversions, optionally chained.
    prev_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = int'($urandom_range(0, 1050));
      c = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      convert(0, k, c, !prev_c);
      prev_c = c;
    end

    // 1-digit instance.
    convert(1, 7, 1'b0, 1'b1);
    convert(1, 0, 1'b1, 1'b1);
    convert(1, 9, 1'b1, 1'b0);
    convert(1, 20, 1'b0, 1'b0);          // overrange
    for (int i = 0; i < 4; i++) convert(1, int'($urandom_range(0, 12)), 1'b0, 1'b1);

    repeat (5) @(negedge ck);
    chk("idle_after_all", 32'(busy[0]), 0);
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
